data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | data_mem_responder                                                         |
// | Single-port SRAM front end: 2-entry posted-write buffer, read priority,    |
// | 1-cycle reads with byte-wise forwarding from buffered writes.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            mem_write_enable_i,
  input  logic [31:0]           mem_write_address_i,
  input  logic [31:0]           mem_data_i,
  input  logic                  mem_read_enable_i,
  input  logic [31:0]           mem_read_address_i,
  output logic [31:0]           mem_data_o,
  output logic                  mem_read_valid_o,
  output logic                  busy_o,
  output logic                  sram_en_o,
  output logic [3:0]            sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]           sram_wdata_o,
  input  logic [31:0]           sram_rdata_i
);

  logic [ADDR_WIDTH-1:0] r_buf_addr [2];
  logic [3:0]            r_buf_be   [2];
  logic [31:0]           r_buf_data [2];
  logic                  r_head;
  logic [1:0]            r_count;
  logic [3:0]            r_mask;
  logic [31:0]           r_merge;
  logic                  r_rd_pending;
  logic [31:0]           r_data_hold;

  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic                  w_read;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_tail;
  logic                  w_has_head;
  logic [3:0]            w_fwd_mask;
  logic [31:0]           w_fwd_data;
  logic [31:0]           w_resp;
  logic                  w_unused_addr_bits;

  assign w_rd_addr  = mem_read_address_i[ADDR_WIDTH+1:2];
  assign w_wr_addr  = mem_write_address_i[ADDR_WIDTH+1:2];
  assign w_unused_addr_bits = ^{mem_write_address_i, mem_read_address_i};

  // Gating the read with reset keeps the SRAM port quiet while reset is held.
  assign w_read     = mem_read_enable_i & reset;
  assign w_full     = (r_count == 2'd2);
  assign w_has_head = (r_count != 2'd0);
  assign w_push     = (|mem_write_enable_i) & ~w_full;
  assign w_pop      = ~w_read & w_has_head;
  assign w_tail     = r_head ^ r_count[0];

  assign busy_o       = w_full;
  assign sram_en_o    = w_read | w_pop;
  assign sram_we_o    = w_pop ? r_buf_be[r_head] : 4'h0;
  assign sram_wdata_o = w_pop ? r_buf_data[r_head] : 32'h0;
  assign sram_addr_o  = w_read ? w_rd_addr :
                        (w_pop ? r_buf_addr[r_head] : '0);

  // Older entry first so the younger entry overrides overlapping bytes.
  always_comb begin
    w_fwd_mask = 4'h0;
    w_fwd_data = 32'h0;
    if (w_has_head && r_buf_addr[r_head] == w_rd_addr) begin
      for (int b = 0; b < 4; b++) begin
        if (r_buf_be[r_head][b]) begin
          w_fwd_mask[b]        = 1'b1;
          w_fwd_data[8*b +: 8] = r_buf_data[r_head][8*b +: 8];
        end
      end
    end
    if (w_full && r_buf_addr[~r_head] == w_rd_addr) begin
      for (int b = 0; b < 4; b++) begin
        if (r_buf_be[~r_head][b]) begin
          w_fwd_mask[b]        = 1'b1;
          w_fwd_data[8*b +: 8] = r_buf_data[~r_head][8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_resp = sram_rdata_i;
    for (int b = 0; b < 4; b++) begin
      if (r_mask[b]) w_resp[8*b +: 8] = r_merge[8*b +: 8];
    end
  end

  assign mem_read_valid_o = r_rd_pending;
  assign mem_data_o       = r_rd_pending ? w_resp : r_data_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_buf_addr[i] <= '0;
        r_buf_be[i]   <= 4'h0;
        r_buf_data[i] <= 32'h0;
      end
      r_head       <= 1'b0;
      r_count      <= 2'd0;
      r_mask       <= 4'h0;
      r_merge      <= 32'h0;
      r_rd_pending <= 1'b0;
      r_data_hold  <= 32'h0;
    end else begin
      if (w_push) begin
        r_buf_addr[w_tail] <= w_wr_addr;
        r_buf_be[w_tail]   <= mem_write_enable_i;
        r_buf_data[w_tail] <= mem_data_i;
      end
      if (w_pop) r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      r_rd_pending <= w_read;
      if (w_read) begin
        r_mask  <= w_fwd_mask;
        r_merge <= w_fwd_data;
      end
      if (r_rd_pending) r_data_hold <= w_resp;
    end
  end

endmodule
`default_nettype wire
